axi4lite_master_ctrl: RTL and testbench



---
 rtl/axi4lite_master_ctrl.sv | 133 +++++++++++++
 tb/tb_axi4lite_master_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_ctrl.sv
// axi4lite_master_ctrl: turns level-held store/load requests into single-beat AXI4-Lite transactions.
// Ports: clk/rst (sync, active-high); write_start/addr/data/strobe -> write_busy;
// read_start/addr -> read_data (latched RDATA), read_busy; resp_err pulses in DONE on SLVERR/DECERR;
// m_aw*/m_w*/m_b*/m_ar*/m_r* are the AXI4-Lite master channels, prot tied to 3'b000.
module axi4lite_master_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write_start,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strobe,
   output logic                    write_busy,
   input  logic                    read_start,
   input  logic [ADDR_WIDTH-1:0]   read_addr,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    read_busy,
   output logic                    resp_err,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic [2:0]              m_awprot,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic [2:0]              m_arprot,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;
   logic [2:0]              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, err_q, err_d;
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      err_d     = err_q;
      case (state_q)
         IDLE:
            if (write_start) begin
               state_d   = WR_REQ;
               addr_d    = write_addr;
               wdata_d   = write_data;
               wstrb_d   = write_strobe;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end else if (read_start) begin
               state_d = RD_REQ;
               addr_d  = read_addr;
            end
         WR_REQ: begin
            // AW and W retire independently; leave once neither is still pending
            awvalid_d = awvalid_q & ~m_awready;
            wvalid_d  = wvalid_q & ~m_wready;
            state_d   = (!awvalid_d && !wvalid_d) ? WR_RESP : WR_REQ;
         end
         WR_RESP:
            if (m_bvalid) begin
               err_d   = m_bresp >= 2'b10;
               state_d = DONE;
            end
         RD_REQ:  state_d = m_arready ? RD_RESP : RD_REQ;
         RD_RESP:
            if (m_rvalid) begin
               rdata_d = m_rdata;
               err_d   = m_rresp >= 2'b10;
               state_d = DONE;
            end
         // DONE ignores the still-held start: it belongs to the instruction that just finished
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         err_q     <= err_d;
      end
   end
   assign m_awaddr   = addr_q;
   assign m_araddr   = addr_q;
   assign m_awprot   = 3'b000;
   assign m_arprot   = 3'b000;
   assign m_awvalid  = awvalid_q;
   assign m_wvalid   = wvalid_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign m_bready   = state_q == WR_RESP;
   assign m_arvalid  = state_q == RD_REQ;
   assign m_rready   = state_q == RD_RESP;
   assign read_data  = rdata_q;
   assign resp_err   = (state_q == DONE) && err_q;
   // busy is combinational so the stall covers the request cycle itself
   assign write_busy = state_q == WR_REQ || state_q == WR_RESP || (state_q == IDLE && write_start);
   assign read_busy  = state_q == RD_REQ || state_q == RD_RESP || (state_q == IDLE && read_start);
endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// tb_axi4lite_master_ctrl: random-delay AXI4-Lite slave plus transaction-level model for axi4lite_master_ctrl.
module tb_axi4lite_master_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        write_start = 1'b0, read_start = 1'b0;
   logic [31:0] write_addr = '0, write_data = '0, read_addr = '0;
   logic [3:0]  write_strobe = '0;
   logic        write_busy, read_busy, resp_err;
   logic [31:0] read_data, m_awaddr, m_wdata, m_araddr;
   logic [31:0] m_rdata = '0;
   logic [3:0]  m_wstrb;
   logic [2:0]  m_awprot, m_arprot;
   logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
   logic [1:0]  m_bresp = '0, m_rresp = '0;
   always #5 clk = ~clk;
   axi4lite_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
      .write_strobe(write_strobe), .write_busy(write_busy),
      .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
      .read_busy(read_busy), .resp_err(resp_err),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );
   int          total = 0, bad = 0;
   int          txn_id = 0, seen_id = 0;
   int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
   logic [1:0]  cfg_resp;
   logic [31:0] cfg_rdata;
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done, w_done, ar_done;
   logic [31:0] aw_log, w_log, ar_log;
   logic [3:0]  s_log;
   logic [31:0] last_rd = '0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   // slave: readies/responses change on the falling edge; a handshake flagged here completes on the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst || seen_id != txn_id) begin
            seen_id = txn_id;
            aw_wait = cfg_aw; w_wait = cfg_w; b_wait = cfg_b; ar_wait = cfg_ar; r_wait = cfg_r;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
         end
         if (!rst) begin
            if (aw_hs) begin aw_done = 1; aw_hs = 0; end
            if (w_hs)  begin w_done = 1;  w_hs = 0;  end
            if (ar_hs) begin ar_done = 1; ar_hs = 0; end
            if (b_hs)  begin m_bvalid = 0; b_hs = 0; end
            if (r_hs)  begin m_rvalid = 0; r_hs = 0; end
            m_awready = 0; m_wready = 0; m_arready = 0;
            if (m_awvalid) begin
               if (aw_wait > 0) aw_wait--;
               else begin m_awready = 1; aw_hs = 1; aw_cnt++; aw_log = m_awaddr; end
            end
            if (m_wvalid) begin
               if (w_wait > 0) w_wait--;
               else begin m_wready = 1; w_hs = 1; w_cnt++; w_log = m_wdata; s_log = m_wstrb; end
            end
            if (m_arvalid) begin
               if (ar_wait > 0) ar_wait--;
               else begin m_arready = 1; ar_hs = 1; ar_cnt++; ar_log = m_araddr; end
            end
            if (!m_bvalid && aw_done && w_done && b_cnt == 0) begin
               if (b_wait > 0) b_wait--;
               else begin m_bvalid = 1; m_bresp = cfg_resp; end
            end
            if (m_bvalid && m_bready && !b_hs) begin b_hs = 1; b_cnt++; end
            if (!m_rvalid && ar_done && r_cnt == 0) begin
               if (r_wait > 0) r_wait--;
               else begin m_rvalid = 1; m_rresp = cfg_resp; m_rdata = cfg_rdata; end
            end
            if (m_rvalid && m_rready && !r_hs) begin r_hs = 1; r_cnt++; end
         end
      end
   end
   // one transaction, entered and left at negedge+1 of an IDLE cycle; d is the returned RDATA for reads
   task automatic run_op(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp, input int aww, input int ww,
                         input int bw, input int arw, input int rw, input bit perturb);
      int n = 0;
      int lat = wr ? ((aww > ww ? aww : ww) + 2 + bw) : (arw + 2 + rw);
      cfg_aw = aww; cfg_w = ww; cfg_b = bw; cfg_ar = arw; cfg_r = rw;
      cfg_resp = resp; cfg_rdata = d;
      txn_id++;
      if (wr) begin
         write_start = 1; write_addr = a; write_data = d; write_strobe = s; read_start = both;
      end else begin
         write_start = 0; read_start = 1; read_addr = a;
      end
      #1;
      chk("req_wbusy", 32'(write_busy), 32'(wr));
      chk("req_rbusy", 32'(read_busy), 32'(!wr || both));
      forever begin
         @(negedge clk); #1; n++;
         if (perturb) begin
            if (wr) begin write_addr = $urandom; write_data = $urandom; write_strobe = 4'($urandom); end
            else read_addr = $urandom;
         end
         chk("wbusy", 32'(write_busy), 32'(wr));
         chk("rbusy", 32'(read_busy), 32'(!wr));
         chk("chan", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}),
             wr ? 32'({!aw_done, !w_done, aw_done && w_done, 2'b00}) : 32'({3'b000, !ar_done, ar_done}));
         if ((wr ? b_cnt : r_cnt) != 0) break;
         if (n > 80) begin chk("timeout", 32'(n), 32'(lat)); break; end
      end
      chk("latency", 32'(n), 32'(lat));
      @(negedge clk); #1;
      chk("done_busy", 32'({write_busy, read_busy}), 32'd0);
      chk("done_err", 32'(resp_err), 32'(resp[1]));
      chk("done_chan", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
      if (!wr) last_rd = d;
      chk("done_rdata", read_data, last_rd);
      @(negedge clk); #1;
      chk("idle_err", 32'(resp_err), 32'd0);
      chk("idle_valid", 32'({m_awvalid, m_wvalid, m_arvalid}), 32'd0);
      chk("handshakes", 32'(aw_cnt * 10000 + w_cnt * 1000 + b_cnt * 100 + ar_cnt * 10 + r_cnt),
          wr ? 32'd11100 : 32'd11);
      chk("hold_rdata", read_data, last_rd);
      if (wr) begin
         chk("awaddr", aw_log, a);
         chk("wdata", w_log, d);
         chk("wstrb", 32'(s_log), 32'(s));
      end else chk("araddr", ar_log, a);
   endtask
   task automatic idle_gap();
      write_start = 0; read_start = 0;
      @(negedge clk); #1;
      chk("gap_busy", 32'({write_busy, read_busy}), 32'd0);
   endtask
   task automatic reset_in_rresp();
      cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 20; cfg_resp = 0; cfg_rdata = $urandom;
      txn_id++;
      write_start = 0; read_start = 1; read_addr = 32'h0000_2000;
      for (int k = 0; k < 20 && !m_rready; k++) begin @(negedge clk); #1; end
      chk("reach_rresp", 32'(m_rready), 32'd1);
      rst = 1; read_start = 0;
      @(negedge clk); #1;
      chk("rst_chan", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_busy", 32'({write_busy, read_busy}), 32'd0);
      read_start = 1; #1;
      chk("rst_rbusy_start", 32'(read_busy), 32'd1);
      read_start = 0; rst = 0; last_rd = '0;
      @(negedge clk); #1;
   endtask
   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_chan", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 32'd0);
      chk("reset_rdata", read_data, 32'd0);
      chk("reset_err", 32'(resp_err), 32'd0);
      chk("reset_busy", 32'({write_busy, read_busy}), 32'd0);
      chk("reset_prot", 32'({m_awprot, m_arprot}), 32'd0);
      write_start = 1; #1;
      chk("reset_wbusy", 32'({write_busy, read_busy}), 32'b10);
      read_start = 1; #1;
      chk("reset_both_busy", 32'({write_busy, read_busy}), 32'b11);
      write_start = 0; read_start = 0; rst = 0;
      @(negedge clk); #1;
      run_op(1, 0, 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 2'b00, 0, 0, 0, 0, 0, 0);
      idle_gap();
      run_op(1, 0, 32'h1000_0040, 32'h1234_5678, 4'b0011, 2'b00, 3, 0, 0, 0, 0, 1);
      idle_gap();
      run_op(0, 0, 32'h2000_0010, 32'h8000_00FF, 4'b0000, 2'b00, 0, 0, 0, 0, 5, 1);
      run_op(1, 0, 32'h3000_0000, 32'hCAFE_F00D, 4'b1100, 2'b00, 0, 0, 0, 0, 0, 0);
      run_op(0, 0, 32'h3000_0000, 32'h0BAD_CAFE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
      idle_gap();
      run_op(1, 0, 32'h4000_0008, 32'h5555_AAAA, 4'b1111, 2'b10, 0, 2, 1, 0, 0, 0);
      idle_gap();
      run_op(1, 1, 32'h5000_0000, 32'h0102_0304, 4'b0001, 2'b00, 1, 2, 0, 0, 0, 0);
      run_op(0, 0, 32'h5000_0100, 32'hFEED_0001, 4'b0000, 2'b11, 2, 0, 0, 1, 0, 0);
      idle_gap();
      reset_in_rresp();
      for (int i = 0; i < 40; i++) begin
         bit wr = 1'($urandom_range(0, 1));
         bit both = wr && ($urandom_range(0, 3) == 0);
         run_op(wr, both, $urandom, $urandom, 4'($urandom), 2'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
         if (both)
            run_op(0, 0, $urandom, $urandom, 4'd0, 2'($urandom), 0, 0, 0,
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
         if ($urandom_range(0, 1) == 1) idle_gap();
      end
      idle_gap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end
endmodule
